count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_pkg.sv | 19 +
 rtl/count_checker.sv | 125 ++++++++++++
 tb/tb_count_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the counter/checker pair: the counter width, the
// checker state encoding and the successor rule of the checked sequence.
package count_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Successor of v in the sequence 0..wrap, wrapping back to 0 after wrap.
  function automatic logic [COUNT_W-1:0] next(input logic [COUNT_W-1:0] v,
                                              input logic [COUNT_W-1:0] wrap);
    return (v == wrap) ? '0 : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/count_checker.sv
// count_checker: watches a free-running counter, locks after LOCK_MATCHES
// consecutive consistent beats, and flags/counts sequence errors while locked.
// Optional feature: define COUNT_CHECKER_STICKY_EN to add the err_sticky
// output, which latches the first error until reset.
module count_checker
  import count_pkg::*;
#(
  parameter int WRAP_VAL     = 10,
  parameter int LOCK_MATCHES = 3,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COUNT_W-1:0]   count_in,
  input  logic                 count_vld,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [COUNT_W-1:0]   expected
`ifdef COUNT_CHECKER_STICKY_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam logic [COUNT_W-1:0] WRAP = COUNT_W'(WRAP_VAL);
  localparam logic [4:0]         LOCK = 5'(LOCK_MATCHES);

  state_t       state_reg;
  logic [3:0]   match_cnt_reg;

  logic         in_range;
  logic         hit;
  logic [4:0]   match_inc;
  logic [COUNT_W-1:0] seed_next;
  logic [COUNT_W-1:0] adv_next;

  // Beat classification and the two candidate predictions.
  assign in_range  = (count_in <= WRAP);
  assign hit       = (count_in == expected);
  assign match_inc = {1'b0, match_cnt_reg} + 5'd1;
  assign seed_next = next(count_in, WRAP);
  assign adv_next  = next(expected, WRAP);

  // Lock state machine; every output is a flop updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SYNC;
      match_cnt_reg <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
      expected      <= '0;
`ifdef COUNT_CHECKER_STICKY_EN
      err_sticky    <= 1'b0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (count_vld) begin
        unique case (state_reg)
          SYNC: begin
            // Out-of-range beats carry no usable phase and are dropped.
            if (in_range) begin
              expected      <= seed_next;
              match_cnt_reg <= 4'd1;
              if (LOCK_MATCHES == 1) begin
                state_reg <= LOCKED;
                locked    <= 1'b1;
              end else begin
                state_reg <= LOCKING;
              end
            end
          end
          LOCKING: begin
            if (!in_range) begin
              state_reg     <= SYNC;
              match_cnt_reg <= '0;
            end else if (hit) begin
              expected      <= adv_next;
              match_cnt_reg <= match_inc[3:0];
              if (match_inc >= LOCK) begin
                state_reg <= LOCKED;
                locked    <= 1'b1;
              end
            end else begin
              // Silent reseed: a mismatch before lock is not an error.
              expected      <= seed_next;
              match_cnt_reg <= 4'd1;
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= adv_next;
            end else begin
              err_pulse <= 1'b1;
              locked    <= 1'b0;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
              end
`ifdef COUNT_CHECKER_STICKY_EN
              err_sticky <= 1'b1;
`endif
              if (in_range) begin
                // Lock is dropped on any error, so the reseed always
                // restarts acquisition from LOCKING.
                expected      <= seed_next;
                match_cnt_reg <= 4'd1;
                state_reg     <= LOCKING;
              end else begin
                match_cnt_reg <= '0;
                state_reg     <= SYNC;
              end
            end
          end
          default: begin
            state_reg     <= SYNC;
            match_cnt_reg <= '0;
            locked        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: the driver updates a run-length
// reference model per beat and queues the expected outputs; a monitor pops
// and compares one entry after every rising edge.
`timescale 1ns/1ps
module tb_count_checker;
  import count_pkg::*;

  localparam int WRAP = 10;
  localparam int LOCK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       count_vld = 1'b0;

  logic       locked, err_pulse;
  logic [7:0] err_cnt;
  logic [3:0] expected;
  logic       locked2, err_pulse2;
  logic [1:0] err_cnt2;
  logic [3:0] expected2;
`ifdef COUNT_CHECKER_STICKY_EN
  logic       err_sticky, err_sticky2;
`endif

  count_checker dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_vld(count_vld),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .expected(expected)
`ifdef COUNT_CHECKER_STICKY_EN
    , .err_sticky(err_sticky)
`endif
  );

  // Narrow error counter instance to exercise saturation.
  count_checker #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_vld(count_vld),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .expected(expected2)
`ifdef COUNT_CHECKER_STICKY_EN
    , .err_sticky(err_sticky2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lk;
    int ep;
    int ec;
    int ex;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: length of the current run of consistent beats,
  // predicted next value and total error count.
  int m_run  = 0;
  int m_pred = 0;
  int m_errs = 0;

  function automatic int succ(input int v);
    return (v == WRAP) ? 0 : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pred = 0; m_errs = 0;
  endtask

  // Apply one cycle of stimulus and queue the outputs it must produce.
  task automatic beat(input bit v, input int val);
    exp_t e;
    bit   err;
    @(negedge clk);
    count_vld = v;
    count_in  = 4'(val);
    err = 1'b0;
    if (v) begin
      if (val > WRAP) begin
        err   = (m_run >= LOCK);
        m_run = 0;
      end else if (m_run > 0 && val == m_pred) begin
        if (m_run < 100) m_run++;
        m_pred = succ(val);
      end else begin
        err    = (m_run >= LOCK);
        m_run  = 1;
        m_pred = succ(val);
      end
    end
    if (err) m_errs++;
    e.lk = (m_run >= LOCK) ? 1 : 0;
    e.ep = err ? 1 : 0;
    e.ec = m_errs;
    e.ex = m_pred;
    sb.push_back(e);
    $display("beat vld=%0d val=%0d -> locked=%0d err=%0d errs=%0d exp=%0d",
             v, val, e.lk, e.ep, e.ec, e.ex);
  endtask

  // Monitor: one scoreboard entry is retired after every rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("locked", int'(locked), mon_e.lk);
      chk("err_pulse", int'(err_pulse), mon_e.ep);
      chk("err_cnt", int'(err_cnt), (mon_e.ec > 255) ? 255 : mon_e.ec);
      chk("expected", int'(expected), mon_e.ex);
      chk("err_cnt_w2", int'(err_cnt2), (mon_e.ec > 3) ? 3 : mon_e.ec);
`ifdef COUNT_CHECKER_STICKY_EN
      chk("err_sticky", int'(err_sticky), (mon_e.ec > 0) ? 1 : 0);
`endif
    end
  end

  initial begin
    int v;
    // Reset state.
    #12;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_expected", int'(expected), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Out-of-range beats in SYNC are ignored, then 4 seeds.
    beat(1, 12); beat(1, 15); beat(1, 4);
    // Full wrap sequence with lock after the third beat.
    for (int i = 0; i <= WRAP; i++) beat(1, i);
    beat(1, 0); beat(1, 1); beat(1, 2);
    // Error while locked, then re-lock on 8, 9.
    beat(1, 7); beat(1, 8); beat(1, 9);
    beat(1, 10); beat(1, 0); beat(1, 1); beat(1, 2); beat(1, 3);
    // Two matching beats separated by idle cycles.
    beat(1, 4);
    for (int i = 0; i < 5; i++) beat(0, $urandom_range(0, 15));
    beat(1, 5);
    // Out-of-range while locked is an error and returns to SYNC.
    beat(1, 6); beat(1, 7); beat(1, 13); beat(1, 14);
    // Repeated lock/mismatch rounds to saturate the narrow counter.
    for (int r = 0; r < 4; r++) begin
      beat(1, 0); beat(1, 1); beat(1, 2); beat(1, 7);
    end
    // Randomized traffic: mostly in sequence, with sporadic corruption.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 15);
      else v = m_pred;
      beat(($urandom_range(0, 4) != 0), v);
    end
    // Lock, then assert reset between edges.
    beat(1, 0); beat(1, 1); beat(1, 2); beat(1, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_err_cnt", int'(err_cnt), 0);
    chk("async_expected", int'(expected), 0);
    chk("async_err_pulse", int'(err_pulse), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 9);
    beat(1, 10); beat(1, 0); beat(1, 1);
    beat(0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
